// File: rtl/layer_sequencer_if.sv
// Control bundle between the host, the stage engines and layer_sequencer.
// fsm_state exposes the sequencer's state register for monitors.
interface layer_sequencer_if #(
    parameter int NUM_STAGES = 7,
    parameter int STAGE_W    = 3,
    parameter int CNT_W      = 32
);
    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_skip;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_start;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [STAGE_W-1:0]    cur_stage;
    logic [STAGE_W-1:0]    err_stage;
    logic [CNT_W-1:0]      total_cycles;
    logic [2:0]            fsm_state;

    // Handshake: stage_start[i] is a one-cycle request to engine i; the engine answers by
    // holding stage_done[i] high for at least one cycle, sampled as a level while awaited.
    modport master (
        output start, abort, stage_skip, stage_done,
        input  stage_start, busy, done, error, cur_stage, err_stage, total_cycles, fsm_state
    );
    modport slave (
        input  start, abort, stage_skip, stage_done,
        output stage_start, busy, done, error, cur_stage, err_stage, total_cycles, fsm_state
    );
endinterface

// File: rtl/layer_sequencer.sv
// Launches the CNN stage engines in ascending index order, one at a time, with per-run
// skipping, a per-stage watchdog, abort and a saturating run cycle counter.
module layer_sequencer #(
    parameter int NUM_STAGES     = 7,
    parameter int STAGE_W        = 3,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.slave   bus
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [STAGE_W-1:0]    cur_q, cur_d;
    logic [NUM_STAGES-1:0] skip_q, skip_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [STAGE_W:0]      first_hit, next_hit;
    logic [NUM_STAGES-1:0] cur_onehot;
    logic                  done_cur;
    logic                  in_run;

    // Returns {found, index} of the lowest non-skipped stage at or above lo.
    function automatic logic [STAGE_W:0] find_from(input logic [NUM_STAGES-1:0] skip,
                                                   input int lo);
        logic [STAGE_W:0] r;
        r = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!skip[i] && i >= lo) r = {1'b1, STAGE_W'(i)};
        end
        return r;
    endfunction

    assign cur_onehot = NUM_STAGES'(1) << cur_q;
    assign done_cur   = |(bus.stage_done & cur_onehot);
    assign in_run     = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_NEXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            skip_q  <= '0;
            timer_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            skip_q  <= skip_d;
            timer_q <= timer_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        skip_d    = skip_q;
        timer_d   = timer_q;
        total_d   = total_q;
        first_hit = find_from(bus.stage_skip, 0);
        next_hit  = find_from(skip_q, int'(cur_q) + 1);

        if ((in_run || state_q == S_FINISH) && total_q != '1)
            total_d = total_q + CNT_W'(1);

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (bus.start) begin
                    skip_d  = bus.stage_skip;
                    total_d = '0;
                    if (first_hit[STAGE_W]) begin
                        cur_d   = first_hit[STAGE_W-1:0];
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                // Any done seen here is stale from an earlier run and is deliberately dropped.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (done_cur)
                    state_d = S_NEXT;
                else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1))
                    state_d = S_ERROR;
                else
                    timer_d = timer_q + TIMER_W'(1);
            end
            S_NEXT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (next_hit[STAGE_W]) begin
                    cur_d   = next_hit[STAGE_W-1:0];
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Abort suppresses the launch pulse in the same cycle so a cancelled stage never starts.
    assign bus.stage_start  = (state_q == S_LAUNCH && !bus.abort) ? cur_onehot : '0;
    assign bus.busy         = in_run;
    assign bus.done         = (state_q == S_FINISH);
    assign bus.error        = (state_q == S_ERROR);
    assign bus.err_stage    = (state_q == S_ERROR) ? cur_q : '0;
    assign bus.cur_stage    = cur_q;
    assign bus.total_cycles = total_q;
    assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: three stages, short watchdog, an auto-responding
// stage model and an expected-launch queue checked as launches appear.
module tb_layer_sequencer;
  localparam int NS = 3;
  localparam int SW = 3;
  localparam int TO = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_sequencer_if #(.NUM_STAGES(NS), .STAGE_W(SW), .CNT_W(CW)) bus();

  layer_sequencer #(.NUM_STAGES(NS), .STAGE_W(SW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int resp_cnt[NS];
  bit auto_en;
  logic [NS-1:0] hold;
  int done_cyc;
  int done_cnt;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample current cycle, advance, then drive the stage model's done bits.
  task automatic step();
    logic [NS-1:0] d;
    #1;
    if (bus.stage_start != '0) begin
      check("launch_onehot", 32'($onehot(bus.stage_start)), 32'd1);
      for (int i = 0; i < NS; i++) begin
        if (bus.stage_start[i]) begin
          resp_cnt[i] = 5;
          if (exp_q.size() == 0) check("unexpected_launch", 32'(cyc * 8 + i), 32'hFFFF_FFFF);
          else check("launch", 32'(cyc * 8 + i), exp_q.pop_front());
        end
      end
    end
    if (bus.done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      d[i] = 1'b0;
      if (resp_cnt[i] > 0) begin
        resp_cnt[i]--;
        d[i] = auto_en && (resp_cnt[i] == 0);
      end
    end
    bus.stage_done = d | hold;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic clear_resp();
    for (int i = 0; i < NS; i++) resp_cnt[i] = 0;
    bus.stage_done = hold;
  endtask

  task automatic begin_test(input logic [NS-1:0] skip);
    clear_resp();
    done_cnt = 0;
    done_cyc = -1;
    bus.stage_skip = skip;
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic settle(input string tag);
    run_to(cyc + 4);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stage_skip = '0;
    bus.stage_done = '0;
    hold = '0;
    auto_en = 1'b1;
    cyc = 0;
    clear_resp();
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_start", 32'(bus.stage_start), 0);
    check("rst_cur", 32'(bus.cur_stage), 0);
    check("rst_total", bus.total_cycles, 0);
    check("rst_state", 32'(bus.fsm_state), 0);
    rst = 1'b0;
    step();

    // Test 1: all stages, done 5 cycles after each launch
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(8 * 8 + 1); exp_q.push_back(15 * 8 + 2);
    begin_test(3'b000);
    run_to(12);
    check("t1_busy_mid", 32'(bus.busy), 1);
    check("t1_cur_mid", 32'(bus.cur_stage), 1);
    run_to(24);
    check("t1_done_cyc", 32'(done_cyc), 22);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_total", bus.total_cycles, 22);
    check("t1_busy_end", 32'(bus.busy), 0);
    settle("t1_all_launched");

    // Test 2: skip stage 1
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(8 * 8 + 2);
    begin_test(3'b010);
    run_to(18);
    check("t2_done_cyc", 32'(done_cyc), 15);
    check("t2_total", bus.total_cycles, 15);
    settle("t2_all_launched");

    // Test 3: stage 0 never answers -> watchdog error, cleared by restart
    auto_en = 1'b0;
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(31 * 8 + 0);
    begin_test(3'b000);
    run_to(17);
    check("t3_no_err_yet", 32'(bus.error), 0);
    check("t3_busy_wait", 32'(bus.busy), 1);
    run_to(18);
    check("t3_error", 32'(bus.error), 1);
    check("t3_err_stage", 32'(bus.err_stage), 0);
    check("t3_busy_err", 32'(bus.busy), 0);
    check("t3_total_err", bus.total_cycles, 17);
    run_to(30);
    check("t3_error_sticky", 32'(bus.error), 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t3_err_cleared", 32'(bus.error), 0);
    check("t3_total_cleared", bus.total_cycles, 0);
    run_to(32);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t3_abort_idle", 32'(bus.fsm_state), 0);
    settle("t3_all_launched");

    // Test 3b: timeout on a later stage reports its index
    exp_q.push_back(1 * 8 + 2);
    begin_test(3'b011);
    run_to(18);
    check("t3b_error", 32'(bus.error), 1);
    check("t3b_err_stage", 32'(bus.err_stage), 2);
    bus.stage_skip = 3'b111;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("t3b_err_cleared", 32'(bus.error), 0);
    check("t3b_err_stage_clr", 32'(bus.err_stage), 0);
    check("t3b_finish", 32'(bus.done), 1);
    settle("t3b_all_launched");

    // Test 4: stale done on stage 0; non-current done bits ignored
    hold = 3'b001;
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(4 * 8 + 1);
    begin_test(3'b000);
    run_to(2);
    check("t4_wait_cur", 32'(bus.cur_stage), 0);
    check("t4_wait_busy", 32'(bus.busy), 1);
    run_to(3);
    check("t4_next", 32'(bus.fsm_state), 3);
    run_to(5);
    hold = 3'b101;
    run_to(12);
    check("t4_still_wait", 32'(bus.fsm_state), 2);
    check("t4_cur1", 32'(bus.cur_stage), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    hold = '0;
    clear_resp();
    check("t4_abort_busy", 32'(bus.busy), 0);
    check("t4_no_done", 32'(done_cnt), 0);
    settle("t4_all_launched");

    // Test 5: abort coincident with done, abort in LAUNCH, then a normal run
    auto_en = 1'b1;
    exp_q.push_back(1 * 8 + 0);
    begin_test(3'b000);
    run_to(6);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_idle", 32'(bus.fsm_state), 0);
    check("t5_total", bus.total_cycles, 6);
    run_to(12);
    check("t5_no_done", 32'(done_cnt), 0);
    check("t5_no_more", 32'(exp_q.size()), 0);
    begin_test(3'b000);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_launch_abort", 32'(bus.busy), 0);
    check("t5_launch_total", bus.total_cycles, 1);
    settle("t5_no_launch");
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(8 * 8 + 1); exp_q.push_back(15 * 8 + 2);
    begin_test(3'b000);
    run_to(24);
    check("t5_rerun_done", 32'(done_cyc), 22);
    settle("t5_all_launched");

    // Test 6: skip all; start while busy; reset mid-WAIT
    begin_test(3'b111);
    check("t6_done_now", 32'(bus.done), 1);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_no_start", 32'(bus.stage_start), 0);
    run_to(3);
    check("t6_done_cnt", 32'(done_cnt), 1);
    check("t6_total", bus.total_cycles, 1);
    exp_q.push_back(1 * 8 + 0); exp_q.push_back(8 * 8 + 1); exp_q.push_back(15 * 8 + 2);
    begin_test(3'b000);
    run_to(3);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    run_to(10);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    run_to(24);
    check("t6_busy_start_done", 32'(done_cyc), 22);
    check("t6_busy_start_cnt", 32'(done_cnt), 1);
    check("t6_busy_start_total", bus.total_cycles, 22);
    settle("t6_all_launched");
    exp_q.push_back(1 * 8 + 0);
    begin_test(3'b000);
    run_to(4);
    rst = 1'b1;
    step();
    check("t6_rst_start", 32'(bus.stage_start), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_done", 32'(bus.done), 0);
    check("t6_rst_error", 32'(bus.error), 0);
    check("t6_rst_cur", 32'(bus.cur_stage), 0);
    check("t6_rst_err_stage", 32'(bus.err_stage), 0);
    check("t6_rst_total", bus.total_cycles, 0);
    rst = 1'b0;
    clear_resp();
    run_to(10);
    check("t6_after_rst_busy", 32'(bus.busy), 0);
    settle("t6_no_relaunch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
